serial_sub_ctrl: RTL and testbench

- Controller that computes an N-bit difference A − B by sequencing a single 1-bit full-subtractor cell over the operands, one bit per clock, LSB first.
- Uses a start/busy/done handshake.
- Provides a low-area subtract unit for the day-to-day arithmetic blocks.
- Wraps the 1-bit subtractor datapath with operand/result shift registers, a bit counter and a 3-state FSM.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/fs_bit_cell.sv | 23 ++
 rtl/serial_sub_ctrl.sv | 106 ++++++++++
 tb/tb_serial_sub_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and the default width.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: x - y - bin, built from two half-subtractor
// stages whose borrows are ORed.
module fs_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    assign hs1_d = x ^ y;
    assign hs1_b = ~x & y;

    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bo    = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: one fs_bit_cell walked across the operands LSB first,
// with a start/busy/done handshake and registered results.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             borrow;
    logic [CNT_W-1:0] cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] a_nx;
    logic [WIDTH-1:0] b_nx;
    logic [WIDTH-1:0] r_nx;

    fs_bit_cell u_cell (
        .x   (a_sh[0]),
        .y   (b_sh[0]),
        .bin (borrow),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // NOTE: every always_comb output gets a full default first, so no path can infer a latch.
    // Shift-by-one written this way stays legal for WIDTH=1 as well.
    always_comb begin
        a_nx            = a_sh >> 1;
        b_nx            = b_sh >> 1;
        r_nx            = r_sh >> 1;
        r_nx[WIDTH-1]   = cell_d;
    end

    // NOTE: sequential state uses non-blocking assignments only; the shift registers are
    // plain flops (not a memory array), so they take a reset value like everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        r_sh   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_nx;
                    b_sh   <= b_nx;
                    r_sh   <= r_nx;
                    borrow <= cell_bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff  <= r_nx;
                        bout  <= cell_bo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed and random checks of serial_sub_ctrl at WIDTH = 8, 1 and 13.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic        start8,  start1,  start13;
    logic [7:0]  a8,  b8;
    logic        a1,  b1;
    logic [12:0] a13, b13;
    logic        busy8,  busy1,  busy13;
    logic        done8,  done1,  done13;
    logic [7:0]  diff8;
    logic        diff1;
    logic [12:0] diff13;
    logic        bout8,  bout1,  bout13;

    int checks     = 0;
    int errors     = 0;
    int seen_done  = 0;
    int exp_done   = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
    );

    serial_sub_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .diff(diff13), .bout(bout13)
    );

    always @(negedge clk) begin
        seen_done <= seen_done + int'(done8) + int'(done1) + int'(done13);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
        case (w)
            1:  begin start1  = s; a1  = av[0];    b1  = bv[0];    end
            8:  begin start8  = s; a8  = av[7:0];  b8  = bv[7:0];  end
            default: begin start13 = s; a13 = av[12:0]; b13 = bv[12:0]; end
        endcase
    endtask

    task automatic sample(input int w, output logic bz, output logic dn,
                          output logic [31:0] df, output logic bo);
        case (w)
            1:  begin bz = busy1;  dn = done1;  df = {31'b0, diff1};  bo = bout1;  end
            8:  begin bz = busy8;  dn = done8;  df = {24'b0, diff8};  bo = bout8;  end
            default: begin bz = busy13; dn = done13; df = {19'b0, diff13}; bo = bout13; end
        endcase
    endtask

    // Full operation: start presented for one edge, busy checked every RUN cycle,
    // done/diff/bout checked in the DONE cycle, then the return to IDLE.
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_diff, input logic exp_bout, input string tag);
        logic bz, dn, bo;
        logic [31:0] df;
        @(negedge clk);
        drive(w, 1'b1, av, bv);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (k == 0) drive(w, 1'b0, ~av, ~bv);
            sample(w, bz, dn, df, bo);
            check({tag, "_busy_run"}, {31'b0, bz}, 32'd1);
            check({tag, "_done_run"}, {31'b0, dn}, 32'd0);
        end
        @(negedge clk);
        sample(w, bz, dn, df, bo);
        check({tag, "_busy_done"}, {31'b0, bz}, 32'd0);
        check({tag, "_done"},      {31'b0, dn}, 32'd1);
        check({tag, "_diff"},      df,          exp_diff);
        check({tag, "_bout"},      {31'b0, bo}, {31'b0, exp_bout});
        exp_done++;
        @(negedge clk);
        sample(w, bz, dn, df, bo);
        check({tag, "_done_clr"},  {31'b0, dn}, 32'd0);
        check({tag, "_busy_idle"}, {31'b0, bz}, 32'd0);
        check({tag, "_diff_hold"}, df,          exp_diff);
    endtask

    function automatic logic [32:0] model(input int w, input logic [31:0] av, input logic [31:0] bv);
        logic [32:0] m;
        m = (33'd1 << w) - 33'd1;
        return ({1'b0, av} & m) - ({1'b0, bv} & m);
    endfunction

    initial begin
        logic bz, dn, bo;
        logic [31:0] df, av, bv, mask;
        logic [32:0] full;

        rst_n = 1'b0;
        drive(8, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 32'h0);
        drive(13, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset state of every instance
        sample(8, bz, dn, df, bo);
        check("rst8_busy", {31'b0, bz}, 32'd0);
        check("rst8_done", {31'b0, dn}, 32'd0);
        check("rst8_diff", df, 32'd0);
        check("rst8_bout", {31'b0, bo}, 32'd0);
        sample(1, bz, dn, df, bo);
        check("rst1_all", {28'b0, bz, dn, df[0], bo}, 32'd0);
        sample(13, bz, dn, df, bo);
        check("rst13_all", {bz, dn, bo, df[28:0]}, 32'd0);
        rst_n = 1'b1;

        // Directed WIDTH=8 vectors
        run_op(8, 32'h5A, 32'h3C, 32'h1E, 1'b0, "v5A_3C");
        run_op(8, 32'h00, 32'h01, 32'hFF, 1'b1, "v00_01");

        // Reset in the fourth RUN cycle aborts the operation
        @(negedge clk);
        drive(8, 1'b1, 32'h5A, 32'h3C);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) drive(8, 1'b0, 32'h0, 32'h0);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sample(8, bz, dn, df, bo);
        check("midrst_busy", {31'b0, bz}, 32'd0);
        check("midrst_done", {31'b0, dn}, 32'd0);
        check("midrst_diff", df, 32'd0);
        check("midrst_bout", {31'b0, bo}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sample(8, bz, dn, df, bo);
            check("midrst_no_done", {30'b0, bz, dn}, 32'd0);
        end
        run_op(8, 32'h5A, 32'h3C, 32'h1E, 1'b0, "after_rst");

        run_op(8, 32'h80, 32'h80, 32'h00, 1'b0, "v80_80");
        run_op(8, 32'hFF, 32'h00, 32'hFF, 1'b0, "vFF_00");

        // start held high with operands changing during RUN and DONE
        @(negedge clk);
        drive(8, 1'b1, 32'h10, 32'h01);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drive(8, 1'b1, 32'hAA, 32'h55);
            check("held_busy_run", {31'b0, busy8}, 32'd1);
            check("held_done_run", {31'b0, done8}, 32'd0);
        end
        @(negedge clk);
        check("held_done", {31'b0, done8}, 32'd1);
        check("held_diff", {24'b0, diff8}, 32'h0F);
        check("held_bout", {31'b0, bout8}, 32'd0);
        exp_done++;
        @(negedge clk);
        check("held_idle_done", {31'b0, done8}, 32'd0);
        check("held_idle_busy", {31'b0, busy8}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drive(8, 1'b0, 32'h0, 32'h0);
            check("held2_busy_run", {31'b0, busy8}, 32'd1);
            check("held2_done_run", {31'b0, done8}, 32'd0);
        end
        @(negedge clk);
        check("held2_done", {31'b0, done8}, 32'd1);
        check("held2_diff", {24'b0, diff8}, 32'h55);
        check("held2_bout", {31'b0, bout8}, 32'd0);
        exp_done++;
        @(negedge clk);
        check("held2_done_clr", {31'b0, done8}, 32'd0);

        // WIDTH=1 exhaustive
        run_op(1, 32'd0, 32'd0, 32'd0, 1'b0, "w1_00");
        run_op(1, 32'd0, 32'd1, 32'd1, 1'b1, "w1_01");
        run_op(1, 32'd1, 32'd0, 32'd1, 1'b0, "w1_10");
        run_op(1, 32'd1, 32'd1, 32'd0, 1'b0, "w1_11");

        // Random operations against {bout,diff} = {0,a} - {0,b}
        for (int i = 0; i < 1000; i++) begin
            mask = 32'h0000_00FF;
            av   = $urandom() & mask;
            bv   = $urandom() & mask;
            full = model(8, av, bv);
            run_op(8, av, bv, full[31:0] & mask, full[8], "rnd8");
        end
        for (int i = 0; i < 1000; i++) begin
            mask = 32'h0000_1FFF;
            av   = $urandom() & mask;
            bv   = $urandom() & mask;
            full = model(13, av, bv);
            run_op(13, av, bv, full[31:0] & mask, full[13], "rnd13");
        end

        @(negedge clk);
        @(negedge clk);
        check("done_count", seen_done, exp_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
